// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic MAC array edge logic.
//   DefDataW / DefLanes : default sample width and samples per packed word
//   collector_state_t   : result collector output-buffer state
//   word_t              : packed word at the default geometry
package systolic_pkg;

   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefLanes = 7;

   // EMPTY: nothing to emit; PENDING: out_data valid, collecting next word;
   // FULL: out_data valid and a second complete word parked in the shift register.
   typedef enum logic [1:0] {EMPTY, PENDING, FULL} collector_state_t;

   typedef logic [DefLanes*DefDataW-1:0] word_t;

endpackage

// File: rtl/collector_shift_reg.sv
// Lane shift register and counter for the result collector.
//   clk, reset   : clock, asynchronous active-high reset
//   clear_i      : synchronous flush of the partial word (wins over accept_i)
//   accept_i     : a sample is taken this edge
//   data_i       : sample, inserted at the LSBs
//   shift_o      : current shift register contents (holds a parked word when the top is FULL)
//   word_o       : word as it would look after this accept; the completed word when complete_o
//   complete_o   : this accept fills the last lane
module collector_shift_reg
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned LANES  = DefLanes
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear_i,
   input  logic                     accept_i,
   input  logic [DATA_W-1:0]        data_i,
   output logic [LANES*DATA_W-1:0]  shift_o,
   output logic [LANES*DATA_W-1:0]  word_o,
   output logic                     complete_o
);

   localparam int unsigned WordW = LANES * DATA_W;
   localparam int unsigned CntW  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CntW-1:0] LastLane = CntW'(LANES - 1);

   logic [WordW-1:0] shift_q, shift_d, shifted;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             last_lane;

   // Shift left one lane, new sample into the LSBs; oldest sample ends up in the MSBs.
   always_comb begin
      shifted = shift_q << DATA_W;
      shifted[DATA_W-1:0] = data_i;
   end

   assign last_lane  = (cnt_q == LastLane);
   assign complete_o = accept_i && !clear_i && last_lane;
   assign word_o     = shifted;
   assign shift_o    = shift_q;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (accept_i) begin
         shift_d = shifted;
         cnt_d   = last_lane ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/result_collector.sv
// Serial-to-parallel packer at the output edge of the systolic MAC array.
// Packs LANES samples per word, first sample in the MSBs, double-buffered so that
// collection continues while a finished word waits for out_ready_i.
//   clk, reset    : clock, asynchronous active-high reset
//   clear_i       : synchronous flush of partial and pending words (word_cnt_o kept)
//   in_valid_i    : in_data_i carries a sample
//   in_data_i     : raw sample bits, never sign-extended
//   in_ready_o    : a sample can be accepted this cycle (depends on state only)
//   out_valid_o   : out_data_o holds a complete word
//   out_data_o    : packed word, sample 0 in the top DATA_W bits
//   out_ready_i   : downstream takes out_data_o this cycle
//   word_cnt_o    : words handed off, wraps at 2^16
module result_collector
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned LANES  = DefLanes
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear_i,
   input  logic                     in_valid_i,
   input  logic [DATA_W-1:0]        in_data_i,
   output logic                     in_ready_o,
   output logic                     out_valid_o,
   output logic [LANES*DATA_W-1:0]  out_data_o,
   input  logic                     out_ready_i,
   output logic [15:0]              word_cnt_o
);

   localparam int unsigned WordW = LANES * DATA_W;

   collector_state_t state_q, state_d;
   logic [WordW-1:0] out_q, out_d;
   logic [15:0]      word_cnt_q, word_cnt_d;
   logic [WordW-1:0] shift_word, done_word;
   logic             accept, hand_off, complete;

   assign in_ready_o  = (state_q != FULL);
   assign out_valid_o = (state_q != EMPTY);
   assign out_data_o  = out_q;
   assign word_cnt_o  = word_cnt_q;

   assign accept   = in_valid_i && in_ready_o;
   assign hand_off = out_valid_o && out_ready_i;

   collector_shift_reg #(
      .DATA_W (DATA_W),
      .LANES  (LANES)
   ) u_shift (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (clear_i),
      .accept_i   (accept),
      .data_i     (in_data_i),
      .shift_o    (shift_word),
      .word_o     (done_word),
      .complete_o (complete)
   );

   always_comb begin
      state_d    = state_q;
      out_d      = out_q;
      word_cnt_d = word_cnt_q;
      if (clear_i) begin
         state_d = EMPTY;
         out_d   = '0;
      end else begin
         if (hand_off) word_cnt_d = word_cnt_q + 16'd1;
         unique case (state_q)
            EMPTY: begin
               if (complete) begin
                  out_d   = done_word;
                  state_d = PENDING;
               end
            end
            PENDING: begin
               if (complete && hand_off) begin
                  out_d = done_word;
               end else if (complete) begin
                  // Finished word stays parked in the shift register until hand-off.
                  state_d = FULL;
               end else if (hand_off) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (hand_off) begin
                  out_d   = shift_word;
                  state_d = PENDING;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= EMPTY;
         out_q      <= '0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         word_cnt_q <= word_cnt_d;
      end
   end

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic [55:0] out_data;
   logic        out_ready = 1'b0;
   logic [15:0] word_cnt;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model: a FIFO of completed words (at most two: the output word plus one
   // parked word) and the list of samples of the word being collected.
   logic [55:0] mq[$];
   logic [7:0]  part[$];
   int          m_cnt = 0;

   always #5 clk = ~clk;

   result_collector #(
      .DATA_W (8),
      .LANES  (7)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (clear),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_ready_i (out_ready),
      .word_cnt_o  (word_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() < 2));
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) chk({tag, ".out_data"}, 64'(out_data), 64'(mq[0]));
      chk({tag, ".word_cnt"}, 64'(word_cnt), 64'(m_cnt));
   endtask

   // One clock: drive inputs, advance the model on the edge, compare #1 after it.
   task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c,
                       input string tag);
      logic        acc, ho;
      logic [55:0] w;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      clear     = c;
      acc = v && (mq.size() < 2);
      ho  = r && (mq.size() > 0);
      @(posedge clk);
      if (c) begin
         mq.delete();
         part.delete();
      end else begin
         if (ho) begin
            void'(mq.pop_front());
            m_cnt = (m_cnt + 1) % 65536;
         end
         if (acc) begin
            part.push_back(d);
            if (part.size() == 7) begin
               w = '0;
               foreach (part[i]) w = (w << 8) | 56'(part[i]);
               mq.push_back(w);
               part.delete();
            end
         end
      end
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mq.delete();
      part.delete();
      m_cnt = 0;
      #1;
      chk("reset.out_valid", 64'(out_valid), 64'd0);
      chk("reset.in_ready", 64'(in_ready), 64'd1);
      chk("reset.word_cnt", 64'(word_cnt), 64'd0);
      chk("reset.out_data", 64'(out_data), 64'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [55:0] sig_word;

   initial begin
      in_valid = 1'b0;
      out_ready = 1'b0;
      clear = 1'b0;

      // 1: basic packing, out_ready high
      do_reset();
      for (int i = 1; i <= 7; i++) step(1'b1, 8'(i * 17), 1'b1, 1'b0, "t1");
      chk("t1.valid_after_last", 64'(out_valid), 64'd1);
      chk("t1.word", 64'(out_data), 64'h11223344556677);
      step(1'b0, 8'h00, 1'b1, 1'b0, "t1.drain");
      chk("t1.word_cnt", 64'(word_cnt), 64'd1);

      // 2: round trip of a feeder word, MSB sample first
      sig_word = 56'hA1B2C3D4E5F607;
      for (int i = 6; i >= 0; i--) step(1'b1, sig_word[i*8 +: 8], 1'b0, 1'b0, "t2");
      chk("t2.round_trip", 64'(out_data), 64'hA1B2C3D4E5F607);
      step(1'b0, 8'h00, 1'b1, 1'b0, "t2.drain");

      // 3: stall to FULL, extra samples ignored, then release
      for (int i = 1; i <= 14; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "t3");
      chk("t3.full_in_ready", 64'(in_ready), 64'd0);
      chk("t3.word1_held", 64'(out_data), 64'h01020304050607);
      for (int i = 0; i < 3; i++) step(1'b1, 8'h99, 1'b0, 1'b0, "t3.ignore");
      chk("t3.word1_stable", 64'(out_data), 64'h01020304050607);
      step(1'b0, 8'h00, 1'b1, 1'b0, "t3.release");
      chk("t3.word2", 64'(out_data), 64'h08090A0B0C0D0E);
      chk("t3.in_ready_back", 64'(in_ready), 64'd1);

      // 4: completion and hand-off on the same edge while PENDING
      for (int i = 1; i <= 6; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "t4");
      step(1'b1, 8'h27, 1'b1, 1'b0, "t4.same_edge");
      chk("t4.valid_kept", 64'(out_valid), 64'd1);
      chk("t4.new_word", 64'(out_data), 64'h21222324252627);
      chk("t4.word_cnt", 64'(word_cnt), 64'd4);
      step(1'b0, 8'h00, 1'b1, 1'b0, "t4.drain");

      // 5: signed samples pass through as raw bits
      sig_word = 56'h80FF017F00FE81;
      for (int i = 6; i >= 0; i--) step(1'b1, sig_word[i*8 +: 8], 1'b0, 1'b0, "t5");
      chk("t5.signed_raw", 64'(out_data), 64'h80FF017F00FE81);
      step(1'b0, 8'h00, 1'b1, 1'b0, "t5.drain");

      // 6: clear discards a partial word, then async reset while FULL
      for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0, 1'b0, "t6.partial");
      step(1'b1, 8'hEE, 1'b1, 1'b1, "t6.clear");
      chk("t6.clear_cnt_kept", 64'(word_cnt), 64'd6);
      for (int i = 1; i <= 7; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "t6");
      chk("t6.after_clear", 64'(out_data), 64'h01020304050607);
      for (int i = 1; i <= 7; i++) step(1'b1, 8'(i + 8'h40), 1'b0, 1'b0, "t6.fill");
      chk("t6.full", 64'(in_ready), 64'd0);
      #2;
      do_reset();

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 59) == 0), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
